seq_alu_n: RTL and testbench

Parametrised successor to the lab-3 add/subtract datapath. It holds operand registers A and B, a result register R (plus R_HI) and a condition-code register CC. On START it executes one of eight operations: single-cycle add, subtract, logic and shift, or a multi-cycle signed radix-2 Booth multiply. It sits between the switch/UI front end (NUM, load strobes) and the display logic, and reports completion with a BUSY/DONE handshake.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_n_add_sub.sv | 24 ++
 rtl/seq_alu_n.sv | 190 +++++++++++++++++++
 tb/tb_seq_alu_n.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU slice.
// Op codes, FSM states and condition-code bit positions.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SHL,
    OP_SRA,
    OP_MUL
  } op_e;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  localparam int CC_COUT = 0;
  localparam int CC_NEG  = 1;
  localparam int CC_ZERO = 2;
  localparam int CC_OVR  = 3;

endpackage

// File: rtl/seq_alu_n_add_sub.sv
// Shared adder/subtractor for ADD/SUB and the Booth step.
// Reports carry-out and carry into the MSB for overflow.
module add_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [WIDTH-1:0] yy;
  logic [WIDTH:0]   full;

  assign yy   = sub ? ~y : y;
  assign full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, sub};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];
  // MSB sum bit = x ^ y ^ carry-in, so carry-in falls out directly
  assign cmsb = x[WIDTH-1] ^ yy[WIDTH-1] ^ full[WIDTH-1];

endmodule

// File: rtl/seq_alu_n.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops
// plus a multi-cycle signed radix-2 Booth multiply.
module seq_alu_n
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLEAR_N,
  input  logic [WIDTH-1:0] NUM,
  input  logic             LOAD_A,
  input  logic             LOAD_B,
  input  logic [2:0]       OP,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] A_OUT,
  output logic [WIDTH-1:0] B_OUT,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] R_HI,
  output logic [3:0]       CC
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state;
  op_e              op;
  logic [WIDTH-1:0] a_q, b_q, mc_q;
  logic [WIDTH-1:0] r_q, rh_q;
  logic [3:0]       cc_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             qm1_q;
  logic [SH_W-1:0]  cnt_q;

  logic [WIDTH-1:0] ax, ay, sum;
  logic             asub, cout, cmsb;
  logic [1:0]       pair;

  assign op   = op_e'(OP);
  assign pair = {lo_q[0], qm1_q};

  always_comb begin
    ax   = a_q;
    ay   = b_q;
    asub = (op == OP_SUB);
    if (state == MUL) begin
      ax   = hi_q;
      ay   = mc_q;
      asub = (pair == 2'b10);
    end
  end

  add_sub_n #(.WIDTH(WIDTH)) u_add (
    .x    (ax),
    .y    (ay),
    .sub  (asub),
    .sum  (sum),
    .cout (cout),
    .cmsb (cmsb)
  );

  // Booth step; true sign of the add keeps the -2^(W-1) case exact
  logic [WIDTH-1:0] acc, hi_nx, lo_nx;
  logic             acc_s;
  logic [3:0]       mcc;

  always_comb begin
    acc   = hi_q;
    acc_s = hi_q[WIDTH-1];
    if (pair[1] ^ pair[0]) begin
      acc   = sum;
      acc_s = sum[WIDTH-1] ^ cmsb ^ cout;
    end
    hi_nx = {acc_s, acc[WIDTH-1:1]};
    lo_nx = {acc[0], lo_q[WIDTH-1:1]};
    mcc          = '0;
    mcc[CC_ZERO] = ({hi_nx, lo_nx} == '0);
    mcc[CC_NEG]  = hi_nx[WIDTH-1];
    mcc[CC_OVR]  = (hi_nx != {WIDTH{lo_nx[WIDTH-1]}});
  end

  logic [SH_W-1:0]         sh;
  logic [WIDTH:0]          shl_x;
  logic signed [WIDTH:0]   sra_x;
  logic [WIDTH-1:0]        r_nx;
  logic                    c_nx, v_nx;
  logic [3:0]              cc_nx;

  assign sh    = b_q[SH_W-1:0];
  assign shl_x = {1'b0, a_q} << sh;
  assign sra_x = $signed({a_q, 1'b0}) >>> sh;

  always_comb begin
    r_nx = '0;
    c_nx = 1'b0;
    v_nx = 1'b0;
    unique case (1'b1)
      (op == OP_ADD),
      (op == OP_SUB): begin
        r_nx = sum;
        c_nx = cout;
        v_nx = cmsb ^ cout;
      end
      (op == OP_AND): r_nx = a_q & b_q;
      (op == OP_OR):  r_nx = a_q | b_q;
      (op == OP_XOR): r_nx = a_q ^ b_q;
      (op == OP_SHL): begin
        r_nx = shl_x[WIDTH-1:0];
        c_nx = shl_x[WIDTH];
      end
      (op == OP_SRA): begin
        r_nx = sra_x[WIDTH:1];
        c_nx = sra_x[0];
      end
      default: ;
    endcase
    cc_nx          = '0;
    cc_nx[CC_COUT] = c_nx;
    cc_nx[CC_NEG]  = r_nx[WIDTH-1];
    cc_nx[CC_ZERO] = (r_nx == '0);
    cc_nx[CC_OVR]  = v_nx;
  end

  always_ff @(posedge CLK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mc_q   <= '0;
      r_q    <= '0;
      rh_q   <= '0;
      cc_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (LOAD_A) a_q <= NUM;
          if (LOAD_B) b_q <= NUM;
          if (START) begin
            if (op == OP_MUL) begin
              state  <= MUL;
              busy_q <= 1'b1;
              mc_q   <= a_q;
              hi_q   <= '0;
              lo_q   <= b_q;
              qm1_q  <= 1'b0;
              cnt_q  <= SH_W'(WIDTH - 1);
            end else begin
              r_q    <= r_nx;
              rh_q   <= {WIDTH{r_nx[WIDTH-1]}};
              cc_q   <= cc_nx;
              done_q <= 1'b1;
            end
          end
        end
        MUL: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          qm1_q <= lo_q[0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            r_q    <= lo_nx;
            rh_q   <= hi_nx;
            cc_q   <= mcc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign A_OUT = a_q;
  assign B_OUT = b_q;
  assign R     = r_q;
  assign R_HI  = rh_q;
  assign CC    = cc_q;

endmodule

// File: tb/tb_seq_alu_n.sv
// Directed bench for seq_alu_n at WIDTH=8.
// Vector table plus hand sequences for MUL corner cases.
module tb_seq_alu_n;

  localparam int W = 8;

  logic         CLK;
  logic         CLEAR_N;
  logic [W-1:0] NUM;
  logic         LOAD_A, LOAD_B;
  logic [2:0]   OP;
  logic         START;
  logic         BUSY, DONE;
  logic [W-1:0] A_OUT, B_OUT, R, R_HI;
  logic [3:0]   CC;

  int checks = 0;
  int errors = 0;

  seq_alu_n #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .CLEAR_N (CLEAR_N),
    .NUM     (NUM),
    .LOAD_A  (LOAD_A),
    .LOAD_B  (LOAD_B),
    .OP      (OP),
    .START   (START),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .A_OUT   (A_OUT),
    .B_OUT   (B_OUT),
    .R       (R),
    .R_HI    (R_HI),
    .CC      (CC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] r;
    logic [7:0] rh;
    logic [3:0] cc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    NUM = a; LOAD_A = 1'b1;
    tick();
    LOAD_A = 1'b0;
    NUM = b; LOAD_B = 1'b1;
    tick();
    LOAD_B = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, nb;
    load(v.a, v.b);
    OP = v.op; START = 1'b1;
    tick();
    START = 1'b0;
    n = 1; nb = 0;
    while (!DONE && n < 20) begin
      if (BUSY) nb++;
      tick();
      n++;
    end
    if (BUSY) nb++;
    chk($sformatf("v%0d_latency", idx), n, (v.op == 3'd7) ? W + 1 : 1);
    chk($sformatf("v%0d_busy", idx), nb, (v.op == 3'd7) ? W : 0);
    chk($sformatf("v%0d_r", idx), R, v.r);
    chk($sformatf("v%0d_rhi", idx), R_HI, v.rh);
    chk($sformatf("v%0d_cc", idx), CC, v.cc);
    tick();
    chk($sformatf("v%0d_done_pulse", idx), DONE, 0);
    chk($sformatf("v%0d_hold_r", idx), R, v.r);
  endtask

  initial begin
    int n, nd;
    // cc = {OVR, ZERO, NEG, COUT}
    vecs.push_back('{8'h7F, 8'h01, 3'd0, 8'h80, 8'hFF, 4'b1010});
    vecs.push_back('{8'h05, 8'h05, 3'd1, 8'h00, 8'h00, 4'b0101});
    vecs.push_back('{8'hFD, 8'h07, 3'd7, 8'hEB, 8'hFF, 4'b0010});
    vecs.push_back('{8'h40, 8'h04, 3'd7, 8'h00, 8'h01, 4'b1000});
    vecs.push_back('{8'h80, 8'h80, 3'd7, 8'h00, 8'h40, 4'b1000});
    vecs.push_back('{8'h81, 8'h01, 3'd5, 8'h02, 8'h00, 4'b0001});
    vecs.push_back('{8'h80, 8'h03, 3'd6, 8'hF0, 8'hFF, 4'b0010});
    vecs.push_back('{8'h5A, 8'h00, 3'd5, 8'h5A, 8'h00, 4'b0000});
    vecs.push_back('{8'hF0, 8'h3C, 3'd2, 8'h30, 8'h00, 4'b0000});
    vecs.push_back('{8'hF0, 8'h0F, 3'd3, 8'hFF, 8'hFF, 4'b0010});
    vecs.push_back('{8'hAA, 8'hAA, 3'd4, 8'h00, 8'h00, 4'b0100});
    vecs.push_back('{8'hFF, 8'h01, 3'd0, 8'h00, 8'h00, 4'b0101});
    vecs.push_back('{8'h03, 8'h05, 3'd1, 8'hFE, 8'hFF, 4'b0010});
    vecs.push_back('{8'h81, 8'h07, 3'd5, 8'h80, 8'hFF, 4'b0010});
    vecs.push_back('{8'h03, 8'h09, 3'd5, 8'h06, 8'h00, 4'b0000});
    vecs.push_back('{8'h05, 8'hFF, 3'd7, 8'hFB, 8'hFF, 4'b0010});
    vecs.push_back('{8'h00, 8'h7F, 3'd7, 8'h00, 8'h00, 4'b0100});
    vecs.push_back('{8'h80, 8'h01, 3'd6, 8'hC0, 8'hFF, 4'b0010});

    CLEAR_N = 1'b0;
    NUM = '0; LOAD_A = 0; LOAD_B = 0; OP = '0; START = 0;
    tick();
    tick();
    chk("rst_r", R, 0);
    chk("rst_rhi", R_HI, 0);
    chk("rst_cc", CC, 0);
    chk("rst_busy_done", {BUSY, DONE}, 0);
    chk("rst_ab", {A_OUT, B_OUT}, 0);
    CLEAR_N = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // load on the START edge: op uses old A, load still lands
    load(8'h10, 8'h20);
    NUM = 8'h01; LOAD_A = 1'b1; OP = 3'd0; START = 1'b1;
    tick();
    LOAD_A = 1'b0; START = 1'b0;
    chk("ls_done", DONE, 1);
    chk("ls_r", R, 8'h30);
    chk("ls_a", A_OUT, 8'h01);
    tick();

    // load and START during MUL are ignored
    load(8'h03, 8'h04);
    OP = 3'd7; START = 1'b1;
    tick();
    NUM = 8'h11; LOAD_A = 1'b1; OP = 3'd0;
    tick();
    LOAD_A = 1'b0; START = 1'b0;
    n = 2;
    while (!DONE && n < 20) begin
      tick();
      n++;
    end
    chk("mb_latency", n, W + 1);
    chk("mb_a", A_OUT, 8'h03);
    chk("mb_r", {R_HI, R}, 16'h000C);
    chk("mb_cc", CC, 4'b0000);
    tick();

    // async clear at edge 3 of a MUL
    load(8'hFD, 8'h07);
    OP = 3'd7; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    chk("ab_busy", BUSY, 1);
    @(posedge CLK);
    CLEAR_N = 1'b0;
    #1;
    chk("ab_r", {R_HI, R}, 0);
    chk("ab_cc", CC, 0);
    chk("ab_ab", {A_OUT, B_OUT}, 0);
    chk("ab_busy_done", {BUSY, DONE}, 0);
    tick();
    nd = 0;
    if (DONE) nd++;
    CLEAR_N = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (DONE || BUSY) nd++;
    end
    chk("ab_no_done", nd, 0);

    run_vec('{8'h12, 8'h34, 3'd0, 8'h46, 8'h00, 4'b0000}, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
